// File: rtl/adc_seq_pkg.sv
// Shared definitions for the SAR conversion sequencer: state encoding and
// default phase configuration.
package adc_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_INIT = 3'd1,
    ST_SAMP = 3'd2,
    ST_COMP = 3'd3,
    ST_UPD  = 3'd4
  } seq_state_e;

  localparam int LEN_W_DEF       = 8;
  localparam int DEF_LEN_INIT    = 1;
  localparam int DEF_LEN_SAMP    = 2;
  localparam int DEF_LEN_COMP    = 2;
  localparam int DEF_LEN_UPDATE  = 1;

endpackage

// File: rtl/adc_seq_phasecnt.sv
// Loadable phase down-counter. A load of L makes `last` assert L cycles later
// (on the L-th cycle of the phase); L=0 behaves as L=1.
module adc_seq_phasecnt #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [LEN_W-1:0] load_len,
  output logic             last
);

  logic [LEN_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = (load_len == '0) ? '0 : load_len - LEN_W'(1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - LEN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == '0);

endmodule

// File: rtl/adc_seqgen.sv
// SAR conversion sequencer: drives one-hot phase strobes to the ADC, collects
// one comparator decision per bit and offers the word on a valid/ready port.
module adc_seqgen
  import adc_seq_pkg::*;
#(
  parameter int NBITS = 16,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cont,
  input  logic [LEN_W-1:0] len_init,
  input  logic [LEN_W-1:0] len_samp,
  input  logic [LEN_W-1:0] len_comp,
  input  logic [LEN_W-1:0] len_update,
  input  logic             comp_out,
  output logic             seq_init,
  output logic             seq_samp,
  output logic             seq_comp,
  output logic             seq_update,
  output logic             busy,
  output logic [NBITS-1:0] result,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             overrun
);

  localparam int IDX_W = (NBITS > 1) ? $clog2(NBITS) : 1;

  seq_state_e       state_q, state_d;
  logic [3:0]       strb_q;
  logic             busy_q;
  logic [LEN_W-1:0] lat_samp_q, lat_comp_q, lat_upd_q;
  logic [IDX_W-1:0] bit_q;
  logic [NBITS-1:0] shreg_q, result_q;
  logic             valid_q, overrun_q;

  logic             ph_load, ph_last;
  logic [LEN_W-1:0] ph_len;
  logic             start_acc, final_upd, begin_init;

  function automatic logic [3:0] strobes_of(input seq_state_e s);
    case (s)
      ST_INIT: strobes_of = 4'b1000;
      ST_SAMP: strobes_of = 4'b0100;
      ST_COMP: strobes_of = 4'b0010;
      ST_UPD:  strobes_of = 4'b0001;
      default: strobes_of = 4'b0000;
    endcase
  endfunction

  adc_seq_phasecnt #(.LEN_W(LEN_W)) u_phasecnt (
    .clk      (clk),
    .rst      (rst),
    .load     (ph_load),
    .load_len (ph_len),
    .last     (ph_last)
  );

  // The counter is reloaded on every phase exit with the length of the phase
  // being entered; INIT always takes its length straight from the input.
  always_comb begin
    start_acc  = (state_q == ST_IDLE) && start;
    final_upd  = (state_q == ST_UPD) && ph_last && (bit_q == '0);
    begin_init = start_acc || (final_upd && cont);
    ph_load    = 1'b0;
    ph_len     = len_init;
    state_d    = state_q;
    case (state_q)
      ST_IDLE: begin
        ph_load = start;
        if (start) state_d = ST_INIT;
      end
      ST_INIT: begin
        ph_load = ph_last;
        ph_len  = lat_samp_q;
        if (ph_last) state_d = ST_SAMP;
      end
      ST_SAMP: begin
        ph_load = ph_last;
        ph_len  = lat_comp_q;
        if (ph_last) state_d = ST_COMP;
      end
      ST_COMP: begin
        ph_load = ph_last;
        ph_len  = lat_upd_q;
        if (ph_last) state_d = ST_UPD;
      end
      ST_UPD: begin
        ph_load = ph_last;
        ph_len  = (bit_q == '0) ? len_init : lat_comp_q;
        if (ph_last) begin
          if (bit_q != '0)  state_d = ST_COMP;
          else if (cont)    state_d = ST_INIT;
          else              state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      strb_q     <= 4'b0000;
      busy_q     <= 1'b0;
      lat_samp_q <= '0;
      lat_comp_q <= '0;
      lat_upd_q  <= '0;
      bit_q      <= '0;
      result_q   <= '0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      strb_q  <= strobes_of(state_d);
      busy_q  <= (state_d != ST_IDLE);

      if (begin_init) begin
        lat_samp_q <= len_samp;
        lat_comp_q <= len_comp;
        lat_upd_q  <= len_update;
        bit_q      <= IDX_W'(NBITS - 1);
      end else if (state_q == ST_UPD && ph_last && bit_q != '0) begin
        bit_q <= bit_q - IDX_W'(1);
      end

      // A load in the same cycle as an accept keeps valid high with the new word.
      if (final_upd) begin
        result_q <= shreg_q;
        valid_q  <= 1'b1;
        if (valid_q && !result_ready) overrun_q <= 1'b1;
      end else if (valid_q && result_ready) begin
        valid_q <= 1'b0;
      end

      if (start_acc) overrun_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == ST_COMP && ph_last) shreg_q[bit_q] <= comp_out;
  end

  assign seq_init     = strb_q[3];
  assign seq_samp     = strb_q[2];
  assign seq_comp     = strb_q[1];
  assign seq_update   = strb_q[0];
  assign busy         = busy_q;
  assign result       = result_q;
  assign result_valid = valid_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_adc_seqgen.sv
// Directed bench for adc_seqgen: phase timing walked cycle by cycle, words
// checked by a queue-based monitor on each valid/ready transfer.
module tb_adc_seqgen;

  logic        clk = 1'b0;
  logic        rst, start, cont, comp_out, result_ready;
  logic [7:0]  len_init, len_samp, len_comp, len_update;
  logic        seq_init, seq_samp, seq_comp, seq_update, busy;
  logic [15:0] result;
  logic        result_valid, overrun;

  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_q[$];

  adc_seqgen #(.NBITS(16), .LEN_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .cont         (cont),
    .len_init     (len_init),
    .len_samp     (len_samp),
    .len_comp     (len_comp),
    .len_update   (len_update),
    .comp_out     (comp_out),
    .seq_init     (seq_init),
    .seq_samp     (seq_samp),
    .seq_comp     (seq_comp),
    .seq_update   (seq_update),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every transfer must match the oldest expected word.
  always @(negedge clk) begin
    if (!rst && result_valid && result_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_word actual=%h expected=none t=%0t", result, $time);
      end else begin
        logic [15:0] w;
        w = exp_q.pop_front();
        chk("result_word", {16'h0, result}, {16'h0, w});
      end
    end
  end

  task automatic kick(input int li, input int ls, input int lc, input int lu);
    len_init   = 8'(li);
    len_samp   = 8'(ls);
    len_comp   = 8'(lc);
    len_update = 8'(lu);
    start      = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic chk_strobe(input string name, input logic [3:0] exp);
    chk(name, {27'h0, seq_init, seq_samp, seq_comp, seq_update, busy}, {27'h0, exp, 1'b1});
  endtask

  // Walks one conversion from its first INIT cycle through its last UPD cycle,
  // checking strobes each cycle and presenting w MSB-first on comp_out.
  task automatic walk(input int li, input int ls, input int lc, input int lu,
                      input logic [15:0] w, input int stop_bit, input bit rdy_last);
    int ei, es, ec, eu;
    ei = (li == 0) ? 1 : li;
    es = (ls == 0) ? 1 : ls;
    ec = (lc == 0) ? 1 : lc;
    eu = (lu == 0) ? 1 : lu;
    for (int c = 0; c < ei; c++) begin @(negedge clk); chk_strobe("phase_init", 4'b1000); end
    for (int c = 0; c < es; c++) begin @(negedge clk); chk_strobe("phase_samp", 4'b0100); end
    for (int b = 0; b < 16; b++) begin
      for (int c = 0; c < ec; c++) begin
        @(negedge clk);
        if (c == 0) comp_out = w[15-b];
        chk_strobe("phase_comp", 4'b0010);
        if (b == stop_bit) return;
      end
      for (int c = 0; c < eu; c++) begin
        if (rdy_last && b == 15 && c == eu - 1) begin
          @(posedge clk);
          #1 result_ready = 1'b1;
        end
        @(negedge clk);
        chk_strobe("phase_upd", 4'b0001);
      end
    end
  endtask

  task automatic chk_done(input string name, input logic [15:0] w, input logic ovr);
    chk({name, "_valid"}, {31'h0, result_valid}, 32'h1);
    chk({name, "_result"}, {16'h0, result}, {16'h0, w});
    chk({name, "_overrun"}, {31'h0, overrun}, {31'h0, ovr});
    chk({name, "_idle"}, {27'h0, seq_init, seq_samp, seq_comp, seq_update, busy}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; cont = 1'b0; comp_out = 1'b0; result_ready = 1'b0;
    len_init = 8'd0; len_samp = 8'd0; len_comp = 8'd0; len_update = 8'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_strobes_busy", {27'h0, seq_init, seq_samp, seq_comp, seq_update, busy}, 32'h0);
    chk("reset_result", {16'h0, result}, 32'h0);
    chk("reset_valid", {31'h0, result_valid}, 32'h0);
    chk("reset_overrun", {31'h0, overrun}, 32'h0);

    // Single shot, lens 1/2/2/1: T=51, valid on cycle 52.
    result_ready = 1'b1;
    exp_q.push_back(16'hAAAA);
    kick(1, 2, 2, 1);
    walk(1, 2, 2, 1, 16'hAAAA, -1, 1'b0);
    chk("single_valid_before", {31'h0, result_valid}, 32'h0);
    @(negedge clk);
    chk_done("single", 16'hAAAA, 1'b0);

    // All lengths zero: every phase one cycle, T=34.
    exp_q.push_back(16'h1234);
    kick(0, 0, 0, 0);
    walk(0, 0, 0, 0, 16'h1234, -1, 1'b0);
    chk("zero_valid_before", {31'h0, result_valid}, 32'h0);
    @(negedge clk);
    chk_done("zero", 16'h1234, 1'b0);

    // start and length changes mid-conversion are ignored.
    exp_q.push_back(16'h5A5A);
    kick(1, 2, 2, 1);
    fork
      walk(1, 2, 2, 1, 16'h5A5A, -1, 1'b0);
      begin
        repeat (5) @(posedge clk);
        #1 start = 1'b1;
        len_init = 8'd3; len_samp = 8'd3; len_comp = 8'd3; len_update = 8'd3;
        repeat (10) @(posedge clk);
        #1 start = 1'b0;
      end
    join
    @(negedge clk);
    chk_done("ignore", 16'h5A5A, 1'b0);

    // Continuous mode with no consumer: second word overwrites the first.
    @(posedge clk);
    #1 result_ready = 1'b0;
    cont = 1'b1;
    exp_q.push_back(16'hF00F);
    kick(0, 0, 0, 0);
    walk(0, 0, 0, 0, 16'h0F0F, -1, 1'b0);
    @(posedge clk);
    #1 cont = 1'b0;
    chk("cont_first_valid", {31'h0, result_valid}, 32'h1);
    chk("cont_first_result", {16'h0, result}, 32'h0F0F);
    chk("cont_first_overrun", {31'h0, overrun}, 32'h0);
    walk(0, 0, 0, 0, 16'hF00F, -1, 1'b0);
    @(negedge clk);
    chk_done("overwrite", 16'hF00F, 1'b1);
    repeat (3) @(negedge clk);
    chk("overrun_sticky", {31'h0, overrun}, 32'h1);
    @(posedge clk);
    #1 result_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("overrun_after_drain", {31'h0, overrun}, 32'h1);
    exp_q.push_back(16'h8001);
    kick(0, 0, 0, 0);
    chk("overrun_cleared_by_start", {31'h0, overrun}, 32'h0);
    walk(0, 0, 0, 0, 16'h8001, -1, 1'b0);
    @(negedge clk);
    chk_done("after_clear", 16'h8001, 1'b0);

    // Accept of the old word in the same cycle the new word loads.
    @(posedge clk);
    #1 result_ready = 1'b0;
    cont = 1'b1;
    exp_q.push_back(16'h1111);
    exp_q.push_back(16'h2222);
    kick(0, 0, 0, 0);
    walk(0, 0, 0, 0, 16'h1111, -1, 1'b0);
    @(posedge clk);
    #1 cont = 1'b0;
    walk(0, 0, 0, 0, 16'h2222, -1, 1'b1);
    @(negedge clk);
    chk_done("accept_and_load", 16'h2222, 1'b0);

    // Reset during bit 7 COMP discards everything.
    @(posedge clk);
    #1 result_ready = 1'b0;
    kick(0, 0, 0, 0);
    walk(0, 0, 0, 0, 16'h3C3C, -1, 1'b0);
    @(negedge clk);
    chk("prereset_valid", {31'h0, result_valid}, 32'h1);
    kick(1, 2, 2, 1);
    walk(1, 2, 2, 1, 16'hFFFF, 8, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_strobes_busy", {27'h0, seq_init, seq_samp, seq_comp, seq_update, busy}, 32'h0);
    chk("midrst_valid", {31'h0, result_valid}, 32'h0);
    chk("midrst_result", {16'h0, result}, 32'h0);
    result_ready = 1'b1;
    exp_q.push_back(16'hC3A5);
    kick(1, 2, 2, 1);
    walk(1, 2, 2, 1, 16'hC3A5, -1, 1'b0);
    chk("postrst_valid_before", {31'h0, result_valid}, 32'h0);
    @(negedge clk);
    chk_done("postrst", 16'hC3A5, 1'b0);

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'h0);
    chk("final_valid", {31'h0, result_valid}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
